// File: rtl/hazard_ctrl.sv
// hazard_ctrl: decode-side sequencing controller for the 5-stage pipeline.
// Tracks the destination registers of the instructions in EX, MEM and WB,
// detects read-after-write hazards against the operands read in ID, and
// drives the PC / pipeline-register enables and clears. It also registers
// the operand forwarding selects consumed by EX and counts data-hazard
// stall cycles.
//
// Each cycle resolves to exactly one mode, highest priority first:
//   FREEZE   - data memory busy: every register holds, nothing flushes.
//   REDIRECT - EX resolved a taken branch/jump: flush IF/ID and ID/EX.
//   STALL    - RAW hazard: hold PC and IF/ID, inject a bubble into EX.
//   RUN      - everything advances.
module hazard_ctrl #(
  parameter bit FWD_EN    = 1'b1,
  parameter bit RF_BYPASS = 1'b1,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             idValid,
  input  logic [4:0]       idRs1,
  input  logic [4:0]       idRs2,
  input  logic             idUseRs1,
  input  logic             idUseRs2,
  input  logic [4:0]       idRd,
  input  logic             idRegWR,
  input  logic             idMemRD,
  input  logic             exRedirect,
  input  logic             memBusy,
  output logic             pcEn,
  output logic             ifidEn,
  output logic             ifidFlush,
  output logic             idexFlush,
  output logic             pipeEn,
  output logic [1:0]       fwdA,
  output logic [1:0]       fwdB,
  output logic [CNT_W-1:0] stallCycles
);

  // One in-flight producer: valid, destination register, is-a-load.
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       ld;
  } sb_entry_t;

  typedef enum logic [1:0] {
    MODE_RUN,
    MODE_FREEZE,
    MODE_REDIRECT,
    MODE_STALL
  } mode_e;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  sb_entry_t ex_s;
  sb_entry_t mem_s;
  sb_entry_t wb_s;

  sb_entry_t ex_nxt;
  mode_e     mode;
  logic      id_writes;
  logic      bubble;
  logic      hz;
  logic      rs1_ex, rs1_mem, rs1_wb;
  logic      rs2_ex, rs2_mem, rs2_wb;
  logic      hz_ex, hz_mem, hz_wb;
  logic [1:0] fwd_a_nxt;
  logic [1:0] fwd_b_nxt;

  // The load flag travels with every entry so all three share one type;
  // once an instruction reaches WB nothing consults it any more.
  logic wb_ld_unused;
  assign wb_ld_unused = wb_s.ld;

  // An entry matches only a real, non-x0 register it actually produces.
  function automatic logic sb_match(input sb_entry_t s, input logic [4:0] r);
    return s.v && (s.rd == r) && (r != 5'd0);
  endfunction

  // Youngest producer wins: EX/MEM result before MEM/WB result.
  function automatic logic [1:0] fwd_pick(input logic hit_ex, input logic hit_mem);
    if (hit_ex)       return FWD_EXMEM;
    else if (hit_mem) return FWD_MEMWB;
    else              return FWD_RF;
  endfunction

  // Source-operand matches against every scoreboard entry.
  always_comb begin
    id_writes = idValid & idRegWR & (idRd != 5'd0);
    rs1_ex    = idUseRs1 & sb_match(ex_s,  idRs1);
    rs1_mem   = idUseRs1 & sb_match(mem_s, idRs1);
    rs1_wb    = idUseRs1 & sb_match(wb_s,  idRs1);
    rs2_ex    = idUseRs2 & sb_match(ex_s,  idRs2);
    rs2_mem   = idUseRs2 & sb_match(mem_s, idRs2);
    rs2_wb    = idUseRs2 & sb_match(wb_s,  idRs2);
  end

  // Hazard detection. With forwarding only a load in EX is too late to
  // forward; without it any EX/MEM producer must drain first. Without a
  // write-through register file a WB producer also blocks the read.
  always_comb begin
    hz_ex  = FWD_EN ? ((rs1_ex | rs2_ex) & ex_s.ld) : (rs1_ex | rs2_ex);
    hz_mem = FWD_EN ? 1'b0 : (rs1_mem | rs2_mem);
    hz_wb  = RF_BYPASS ? 1'b0 : (rs1_wb | rs2_wb);
    hz     = idValid & (hz_ex | hz_mem | hz_wb);
  end

  // Cycle mode selection in priority order.
  always_comb begin
    mode = MODE_RUN;
    if (memBusy)         mode = MODE_FREEZE;
    else if (exRedirect) mode = MODE_REDIRECT;
    else if (hz)         mode = MODE_STALL;
  end

  // Pipeline enables and clears, purely combinational from the mode.
  always_comb begin
    pcEn      = 1'b1;
    ifidEn    = 1'b1;
    ifidFlush = 1'b0;
    idexFlush = 1'b0;
    pipeEn    = 1'b1;
    case (mode)
      MODE_FREEZE: begin
        pcEn   = 1'b0;
        ifidEn = 1'b0;
        pipeEn = 1'b0;
      end
      MODE_REDIRECT: begin
        ifidFlush = 1'b1;
        idexFlush = 1'b1;
      end
      MODE_STALL: begin
        pcEn      = 1'b0;
        ifidEn    = 1'b0;
        idexFlush = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Next EX entry and next forwarding selects for the instruction leaving ID.
  always_comb begin
    bubble    = (mode == MODE_REDIRECT) || (mode == MODE_STALL);
    ex_nxt    = '0;
    fwd_a_nxt = FWD_RF;
    fwd_b_nxt = FWD_RF;
    if (!bubble) begin
      ex_nxt.v  = id_writes;
      ex_nxt.rd = idRd;
      ex_nxt.ld = idMemRD;
    end
    if (FWD_EN && !bubble && idValid) begin
      fwd_a_nxt = fwd_pick(rs1_ex, rs1_mem);
      fwd_b_nxt = fwd_pick(rs2_ex, rs2_mem);
    end
  end

  // Scoreboard shift, forwarding selects and stall counter; all hold while
  // memory is busy so the interrupted cycle is replayed unchanged.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      ex_s        <= '0;
      mem_s       <= '0;
      wb_s        <= '0;
      fwdA        <= FWD_RF;
      fwdB        <= FWD_RF;
      stallCycles <= '0;
    end else if (mode != MODE_FREEZE) begin
      wb_s  <= mem_s;
      mem_s <= ex_s;
      ex_s  <= ex_nxt;
      fwdA  <= fwd_a_nxt;
      fwdB  <= fwd_b_nxt;
      if (mode == MODE_STALL) begin
        stallCycles <= stallCycles + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl. Instance "a" uses full forwarding with a
// write-through register file; instance "b" has no forwarding, no
// write-through and a 4-bit stall counter so wrap-around is reachable.
// Each driven cycle pushes the expected outputs for that cycle; a monitor
// on the falling edge pops and compares them.
module tb_hazard_ctrl;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
    logic       redir;
    logic       busy;
  } stim_t;

  // {sel, ctrl[4:0], fwdA[1:0], fwdB[1:0], cnt[31:0]}
  localparam int EXP_W = 42;
  // ctrl = {pcEn, ifidEn, ifidFlush, idexFlush, pipeEn}
  localparam logic [4:0] C_RUN   = 5'b11001;
  localparam logic [4:0] C_STALL = 5'b00011;
  localparam logic [4:0] C_REDIR = 5'b11111;
  localparam logic [4:0] C_FRZ   = 5'b00000;
  localparam stim_t IDLE = '0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  stim_t stim_a, stim_b;

  logic        a_pc, a_ifid, a_ifidf, a_idexf, a_pipe;
  logic [1:0]  a_fa, a_fb;
  logic [31:0] a_cnt;
  logic        b_pc, b_ifid, b_ifidf, b_idexf, b_pipe;
  logic [1:0]  b_fa, b_fb;
  logic [3:0]  b_cnt;

  hazard_ctrl #(.FWD_EN(1'b1), .RF_BYPASS(1'b1), .CNT_W(32)) dut_a (
    .clk(clk), .rstN(rstN),
    .idValid(stim_a.valid), .idRs1(stim_a.rs1), .idRs2(stim_a.rs2),
    .idUseRs1(stim_a.u1), .idUseRs2(stim_a.u2), .idRd(stim_a.rd),
    .idRegWR(stim_a.wr), .idMemRD(stim_a.ld),
    .exRedirect(stim_a.redir), .memBusy(stim_a.busy),
    .pcEn(a_pc), .ifidEn(a_ifid), .ifidFlush(a_ifidf), .idexFlush(a_idexf),
    .pipeEn(a_pipe), .fwdA(a_fa), .fwdB(a_fb), .stallCycles(a_cnt)
  );

  hazard_ctrl #(.FWD_EN(1'b0), .RF_BYPASS(1'b0), .CNT_W(4)) dut_b (
    .clk(clk), .rstN(rstN),
    .idValid(stim_b.valid), .idRs1(stim_b.rs1), .idRs2(stim_b.rs2),
    .idUseRs1(stim_b.u1), .idUseRs2(stim_b.u2), .idRd(stim_b.rd),
    .idRegWR(stim_b.wr), .idMemRD(stim_b.ld),
    .exRedirect(stim_b.redir), .memBusy(stim_b.busy),
    .pcEn(b_pc), .ifidEn(b_ifid), .ifidFlush(b_ifidf), .idexFlush(b_idexf),
    .pipeEn(b_pipe), .fwdA(b_fa), .fwdB(b_fb), .stallCycles(b_cnt)
  );

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  int    checks = 0;
  int    errors = 0;
  string phase  = "init";

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h at %0t", phase, tag, got, exp, $time);
    end
  endtask

  // Compare the instance named in each expected entry.
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (e[41]) begin
        chk("b_ctrl", {27'd0, b_pc, b_ifid, b_ifidf, b_idexf, b_pipe}, {27'd0, e[40:36]});
        chk("b_fwd",  {28'd0, b_fa, b_fb}, {28'd0, e[35:32]});
        chk("b_cnt",  {28'd0, b_cnt}, e[31:0]);
      end else begin
        chk("a_ctrl", {27'd0, a_pc, a_ifid, a_ifidf, a_idexf, a_pipe}, {27'd0, e[40:36]});
        chk("a_fwd",  {28'd0, a_fa, a_fb}, {28'd0, e[35:32]});
        chk("a_cnt",  a_cnt, e[31:0]);
      end
    end
  end

  // ---------------- driver ----------------
  function automatic stim_t mk(input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic u1, input logic u2,
                               input logic wr, input logic ld);
    stim_t s;
    s       = '0;
    s.valid = 1'b1;
    s.rd    = rd;
    s.rs1   = rs1;
    s.rs2   = rs2;
    s.u1    = u1;
    s.u2    = u2;
    s.wr    = wr;
    s.ld    = ld;
    return s;
  endfunction

  task automatic cyc(input logic sel, input stim_t s, input logic [4:0] ctrl,
                     input logic [1:0] fa, input logic [1:0] fb, input logic [31:0] cnt);
    @(posedge clk);
    #1;
    if (sel) begin
      stim_b = s;
      stim_a = IDLE;
    end else begin
      stim_a = s;
      stim_b = IDLE;
    end
    exp_q.push_back({sel, ctrl, fa, fb, cnt});
  endtask

  task automatic idles(input logic sel, input int n, input logic [31:0] cnt);
    for (int i = 0; i < n; i++) cyc(sel, IDLE, C_RUN, 2'b00, 2'b00, cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    stim_t s;
    stim_t lw7, use7;
    int    c;
    logic [4:0] r, rd2;

    rstN   = 1'b0;
    stim_a = IDLE;
    stim_b = IDLE;
    lw7    = mk(5'd7, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    use7   = mk(5'd8, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);

    phase = "reset";
    cyc(1'b0, IDLE, C_RUN, 2'b00, 2'b00, 32'd0);
    cyc(1'b1, IDLE, C_RUN, 2'b00, 2'b00, 32'd0);
    @(negedge clk);
    #1 rstN = 1'b1;

    // add x5,x1,x2 ; sub x6,x5,x3 -> EX/MEM forward on A, then a freeze
    // must hold the registered selects.
    phase = "fwd_exmem";
    cyc(1'b0, mk(5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0), C_RUN, 2'b00, 2'b00, 32'd0);
    cyc(1'b0, mk(5'd6, 5'd5, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0), C_RUN, 2'b00, 2'b00, 32'd0);
    s = IDLE; s.busy = 1'b1;
    cyc(1'b0, s, C_FRZ, 2'b01, 2'b00, 32'd0);
    cyc(1'b0, s, C_FRZ, 2'b01, 2'b00, 32'd0);
    cyc(1'b0, IDLE, C_RUN, 2'b01, 2'b00, 32'd0);
    idles(1'b0, 2, 32'd0);

    // Two writers of x10, then a reader: the younger (EX) one wins.
    phase = "youngest";
    cyc(1'b0, mk(5'd10, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0), C_RUN, 2'b00, 2'b00, 32'd0);
    cyc(1'b0, mk(5'd10, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0), C_RUN, 2'b00, 2'b00, 32'd0);
    cyc(1'b0, mk(5'd11, 5'd12, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0), C_RUN, 2'b00, 2'b00, 32'd0);
    cyc(1'b0, IDLE, C_RUN, 2'b00, 2'b01, 32'd0);
    idles(1'b0, 3, 32'd0);

    // lw x7 ; add x8,x7,x7 -> one stall, then MEM/WB forward on both.
    phase = "load_use";
    cyc(1'b0, lw7,  C_RUN,   2'b00, 2'b00, 32'd0);
    cyc(1'b0, use7, C_STALL, 2'b00, 2'b00, 32'd0);
    cyc(1'b0, use7, C_RUN,   2'b00, 2'b00, 32'd1);
    cyc(1'b0, IDLE, C_RUN,   2'b10, 2'b10, 32'd1);
    idles(1'b0, 2, 32'd1);

    // Redirect in the would-be stall cycle: flush, no count.
    phase = "redirect";
    cyc(1'b0, lw7, C_RUN, 2'b00, 2'b00, 32'd1);
    s = use7; s.redir = 1'b1;
    cyc(1'b0, s, C_REDIR, 2'b00, 2'b00, 32'd1);
    idles(1'b0, 2, 32'd1);

    // memBusy for 3 cycles over a load-use stall (with a redirect that
    // must be ignored while frozen); the stall then happens once.
    phase = "busy";
    cyc(1'b0, lw7, C_RUN, 2'b00, 2'b00, 32'd1);
    s = use7; s.busy = 1'b1;
    cyc(1'b0, s, C_FRZ, 2'b00, 2'b00, 32'd1);
    s.redir = 1'b1;
    cyc(1'b0, s, C_FRZ, 2'b00, 2'b00, 32'd1);
    s.redir = 1'b0;
    cyc(1'b0, s, C_FRZ, 2'b00, 2'b00, 32'd1);
    cyc(1'b0, use7, C_STALL, 2'b00, 2'b00, 32'd1);
    cyc(1'b0, use7, C_RUN,   2'b00, 2'b00, 32'd2);
    cyc(1'b0, IDLE, C_RUN,   2'b10, 2'b10, 32'd2);
    idles(1'b0, 2, 32'd2);

    // Writes to x0 (including a load) never create a dependency.
    phase = "x0";
    cyc(1'b0, mk(5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0), C_RUN, 2'b00, 2'b00, 32'd2);
    cyc(1'b0, mk(5'd0, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1), C_RUN, 2'b00, 2'b00, 32'd2);
    cyc(1'b0, mk(5'd9, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0), C_RUN, 2'b00, 2'b00, 32'd2);
    idles(1'b0, 2, 32'd2);

    // Reset mid-flight with a load in EX and fwdA=01 already registered.
    phase = "reset_mid";
    cyc(1'b0, mk(5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0), C_RUN, 2'b00, 2'b00, 32'd2);
    cyc(1'b0, mk(5'd7, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1), C_RUN, 2'b00, 2'b00, 32'd2);
    @(posedge clk);
    #1;
    stim_a = use7;
    stim_b = IDLE;
    rstN   = 1'b0;
    exp_q.push_back({1'b0, C_RUN, 2'b00, 2'b00, 32'd0});
    @(negedge clk);
    #1 rstN = 1'b1;
    cyc(1'b0, use7, C_RUN, 2'b00, 2'b00, 32'd0);
    idles(1'b0, 3, 32'd0);

    // No forwarding, no write-through: addi xr,x0 ; add xd,xr,xr gives
    // three stalls each time; the 4-bit counter wraps past 15.
    phase = "nofwd";
    c = 0;
    for (int p = 0; p < 6; p++) begin
      r   = (p == 0) ? 5'd3 : 5'($urandom_range(1, 31));
      rd2 = (p == 0) ? 5'd4 : 5'($urandom_range(1, 31));
      cyc(1'b1, mk(r, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0), C_RUN, 2'b00, 2'b00, 32'(c % 16));
      for (int k = 0; k < 3; k++) begin
        cyc(1'b1, mk(rd2, r, r, 1'b1, 1'b1, 1'b1, 1'b0), C_STALL, 2'b00, 2'b00, 32'((c + k) % 16));
      end
      cyc(1'b1, mk(rd2, r, r, 1'b1, 1'b1, 1'b1, 1'b0), C_RUN, 2'b00, 2'b00, 32'((c + 3) % 16));
      idles(1'b1, 3, 32'((c + 3) % 16));
      c = c + 3;
    end

    @(negedge clk);
    @(negedge clk);
    #1;
    phase = "end";
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core (IF, ID, EX, MEM, WB).
- Keeps a 3-entry scoreboard of in-flight destination registers (EX, MEM, WB) and detects RAW hazards against the operands being read in ID.
- Generates per-stage stall, flush and freeze enables, plus registered forwarding selects consumed by EX.
- Sits beside the decode stage: takes the decoded rs1/rs2/rd and control bits, and drives the pipeline-register enables and clears.

Parameters:
FWD_EN, 1, 1 = EX/MEM and MEM/WB forwarding paths exist; 0 = resolve every RAW hazard by stalling.
RF_BYPASS, 1, 1 = regFile write-through (WB write visible to a same-cycle ID read); 0 = ID stalls on a WB match.
CNT_W, 32, width of the stall-cycle performance counter.

Ports:
clk  input  1  core clock, rising edge
rstN  input  1  asynchronous active-low reset
idValid  input  1  ID holds a real instruction
idRs1  input  5  ID source register 1
idRs2  input  5  ID source register 2
idUseRs1  input  1  ID instruction reads rs1
idUseRs2  input  1  ID instruction reads rs2
idRd  input  5  ID destination register
idRegWR  input  1  ID instruction writes rd
idMemRD  input  1  ID instruction is a load
exRedirect  input  1  branch taken or jump resolved in EX
memBusy  input  1  data memory not ready; freeze pipeline
pcEn  output  1  PC register update enable
ifidEn  output  1  IF/ID register enable
ifidFlush  output  1  IF/ID register clear (bubble)
idexFlush  output  1  ID/EX register clear (bubble)
pipeEn  output  1  enable for ID/EX, EX/MEM and MEM/WB registers
fwdA  output  2  EX operand A select: 00 regfile, 01 EX/MEM, 10 MEM/WB
fwdB  output  2  EX operand B select, same encoding as fwdA
stallCycles  output  CNT_W  count of data-hazard stall cycles

Behaviour:
- Scoreboard entries exS, memS, wbS, each {v, rd[4:0], ld}. On reset: all v=0, fwdA=fwdB=00, stallCycles=0.
- idWrites = idValid & idRegWR & (idRd != 0). An x0 source never matches any entry.
- match(S, r): S.v & (S.rd == r) & (r != 0). Evaluate for rs1 when idUseRs1=1 and for rs2 when idUseRs2=1.
- Hazard stall (hz), combinational, qualified by idValid:
  - FWD_EN=1: asserted when a used source matches exS with exS.ld=1 (load-use, one cycle).
  - FWD_EN=0: asserted when a used source matches exS or memS.
  - RF_BYPASS=0: additionally asserted when a used source matches wbS.
- Priority, highest first: memBusy > exRedirect > hz.
- memBusy=1:
  - pcEn=ifidEn=pipeEn=0, ifidFlush=idexFlush=0.
  - Scoreboard, fwdA/fwdB and counter all hold.
  - exRedirect and hz are ignored for this cycle and re-evaluated once memBusy drops.
- exRedirect=1 (memBusy=0):
  - pcEn=1, ifidEn=1, ifidFlush=1, idexFlush=1, pipeEn=1.
  - exS gets a bubble (v=0). hz is suppressed and not counted.
- hz=1 (no memBusy, no redirect):
  - pcEn=0, ifidEn=0, idexFlush=1, pipeEn=1.
  - exS gets a bubble. stallCycles increments.
- Otherwise: all enables 1, both flushes 0. exS <= {idWrites, idRd, idMemRD}.
- Scoreboard advance, whenever memBusy=0: wbS<=memS, memS<=exS, then exS is loaded as above.
- Forward selects, registered with the same timing as exS load:
  - fwdA <= 01 if rs1 matches exS; else 10 if rs1 matches memS; else 00.
  - fwdB uses the same rule with rs2.
  - The exS match takes precedence, so the youngest producer wins.
  - Forced to 00 when FWD_EN=0, when the source is unused, or when a bubble is inserted.
- stallCycles wraps modulo 2^CNT_W.
- Every output except fwdA, fwdB and stallCycles is combinational, with no added latency.
- Reset asserted mid-operation clears all state immediately. The first instruction after rstN rises sees an empty scoreboard and never stalls.

Test Plan:
- Reset, then "add x5,x1,x2" followed by "sub x6,x5,x3" (FWD_EN=1) -> no stall; the cycle sub is in EX shows fwdA=01, fwdB=00.
- "lw x7,0(x1)" followed by "add x8,x7,x7" -> exactly 1 cycle with pcEn=0, ifidEn=0, idexFlush=1, stallCycles 0->1. Next cycle add advances with fwdA=fwdB=10.
- "lw x7", then load-use dependent, with exRedirect=1 in the stall cycle -> ifidFlush=idexFlush=1, pcEn=1, stallCycles unchanged.
- memBusy high for 3 cycles during a load-use stall -> all enables 0 and state frozen for those 3 cycles; the stall resumes afterwards and stallCycles increments exactly once in total.
- FWD_EN=0, RF_BYPASS=0: "addi x3,x0,1" then "add x4,x3,x3" -> 3 stall cycles, stallCycles=3, fwdA=fwdB=00.
- Writes to x0 followed by reads of x0 -> never stall, fwd=00. Set stallCycles to all-ones (CNT_W=4 build), one more stall -> wraps to 0.
